zpc_mdu: RTL

- Parametrised iterative multiply/divide unit for the ZPC multi-cycle core. It replaces the single-cycle A*B path in the execute stage.
- Computes signed/unsigned W x W multiply (2W-bit product) and signed/unsigned divide (quotient + remainder) at one bit per cycle.
- Uses a start/busy/done handshake so the core controller can stall its stage counter while the unit runs.
- Results are held in HI/LO registers until the next operation completes (MIPS mfhi/mflo semantics).

---
 rtl/zpc_mdu.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/zpc_mdu.sv
// zpc_mdu: iterative multiply/divide unit, one result bit per cycle.
// MULT/MULTU use shift-add over the operand magnitudes, DIV/DIVU use
// restoring division; a FIXUP cycle applies the signs and writes hi/lo.
// Optional build macro ZPC_MDU_EARLY_OUT_EN: multiply RUN stops once the
// remaining multiplier magnitude is zero.
module zpc_mdu #(
    parameter  int W     = 32,
    localparam int CNT_W = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         div_by_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]     prod_q, prod_d;
    logic [2*W-1:0]     mcand_q, mcand_d;
    logic [W-1:0]       mplier_q, mplier_d;
    logic [W-1:0]       rem_q, rem_d;
    logic [W-1:0]       quo_q, quo_d;
    logic [W-1:0]       dvsr_q, dvsr_d;
    logic [W-1:0]       hi_q, hi_d;
    logic [W-1:0]       lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               is_signed;
    logic               is_div;
    logic               accept;
    logic [W-1:0]       mag_a;
    logic [W-1:0]       mag_b;
    logic [W:0]         div_shift;
    logic [W-1:0]       div_sub;
    logic               div_ge;
    logic               run_last;
    logic [2*W-1:0]     prod_fix;

    // Operand decode; negating -2^(W-1) yields 2^(W-1) as an unsigned magnitude.
    assign is_signed = ~op_q[0];
    assign is_div    = op_q[1];
    assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign mag_a     = (is_signed && a_q[W-1]) ? -a_q : a_q;
    assign mag_b     = (is_signed && b_q[W-1]) ? -b_q : b_q;

    // One restoring-division step: bring down the next dividend bit, try to subtract.
    assign div_shift = {rem_q, quo_q[W-1]};
    assign div_ge    = (div_shift >= {1'b0, dvsr_q});
    assign div_sub   = div_shift[W-1:0] - dvsr_q;

    // Next-state and datapath update for every register.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        run_last = 1'b0;
        prod_fix = prod_q;

        if (accept) begin
            op_d  = op;
            a_d   = a;
            b_d   = b;
            dbz_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_PREP;
            end
            S_PREP: begin
                neg_a_d  = is_signed && a_q[W-1];
                neg_b_d  = is_signed && b_q[W-1];
                prod_d   = '0;
                mcand_d  = {{W{1'b0}}, mag_a};
                mplier_d = mag_b;
                rem_d    = '0;
                quo_d    = mag_a;
                dvsr_d   = mag_b;
                cnt_d    = CNT_W'(W);
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (is_div) begin
                    if (div_ge) begin
                        rem_d = div_sub;
                        quo_d = {quo_q[W-2:0], 1'b1};
                    end else begin
                        rem_d = div_shift[W-1:0];
                        quo_d = {quo_q[W-2:0], 1'b0};
                    end
                end else begin
                    if (mplier_q[0]) prod_d = prod_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
                cnt_d    = cnt_q - CNT_W'(1);
                run_last = (cnt_q == CNT_W'(1));
`ifdef ZPC_MDU_EARLY_OUT_EN
                if (!is_div && (mplier_q[W-1:1] == '0)) run_last = 1'b1;
`endif
                if (run_last) state_d = S_FIXUP;
            end
            S_FIXUP: begin
                if (is_div) begin
                    if (b_q == '0) begin
                        lo_d = '1;
                        hi_d = a_q;
                    end else begin
                        lo_d = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
                        hi_d = neg_a_q ? -rem_q : rem_q;
                    end
                end else begin
                    prod_fix     = (neg_a_q ^ neg_b_q) ? -prod_q : prod_q;
                    {hi_d, lo_d} = prod_fix;
                end
                dbz_d   = is_div && (b_q == '0);
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = accept ? S_PREP : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_PREP) || (state_d == S_RUN) || (state_d == S_FIXUP);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and registered handshake outputs; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule
